// File: rtl/multi_cv_regulator.sv
// ---------------------------------------------------------------------------
// multi_cv_regulator
//
// Purpose: bang-bang constant-voltage regulator for NCH independent channels.
// At every refresh tick, each enabled channel compares its measured voltage
// with its set point. It then steps its PWM duty up or down, or leaves it
// unchanged when the error is inside the dead band. Each channel drives a
// PWM output from a shared free-running timer. The duty used by the PWM is
// taken from a shadow copy that reloads only at period boundaries.
//
// Ports:
//   clock      in   1            single clock
//   resetn     in   1            synchronous, active-low reset
//   ch_en      in   NCH          per-channel enable
//   voltage    in   NCH*ADC_W    measured voltages, channel k at [k*ADC_W +: ADC_W]
//   set_point  in   NCH*ADC_W    targets, packed like voltage
//   step       in   STEP_W       duty step per update (shared)
//   tick       out  1            one-cycle regulation update strobe
//   dir        out  NCH*2        00 IDLE, 01 INCREASE, 10 DECREASE
//   duty       out  NCH*CNT_W    per-channel target duty
//   locked     out  NCH          channel has seen LOCK_N consecutive IDLE updates
//   pwm        out  NCH          registered PWM outputs
// ---------------------------------------------------------------------------
module multi_cv_regulator #(
    parameter int NCH      = 2,
    parameter int ADC_W    = 12,
    parameter int CNT_W    = 11,
    parameter int PERIOD   = 1241,
    parameter int DUTY_MAX = 1116,
    parameter int REFRESH  = 6501,
    parameter int DB_LO    = 5,
    parameter int DB_HI    = 10,
    parameter int STEP_W   = 4,
    parameter int LOCK_N   = 8
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic [NCH-1:0]         ch_en,
    input  logic [NCH*ADC_W-1:0]   voltage,
    input  logic [NCH*ADC_W-1:0]   set_point,
    input  logic [STEP_W-1:0]      step,
    output logic                   tick,
    output logic [NCH*2-1:0]       dir,
    output logic [NCH*CNT_W-1:0]   duty,
    output logic [NCH-1:0]         locked,
    output logic [NCH-1:0]         pwm
);

    localparam int RC_W  = $clog2(REFRESH + 1);
    localparam int LK_W  = $clog2(LOCK_N + 1);
    localparam int SUM_W = CNT_W + 1;

    typedef enum logic [1:0] {
        DIR_IDLE = 2'b00,
        DIR_INC  = 2'b01,
        DIR_DEC  = 2'b10
    } dir_t;

    logic [RC_W-1:0]  r_refresh;
    logic [CNT_W-1:0] r_timer;
    logic             w_tick;
    logic             w_period_end;

    assign w_tick       = (r_refresh == RC_W'(REFRESH - 1));
    assign w_period_end = (r_timer == CNT_W'(PERIOD - 1));
    assign tick         = w_tick;

    // Shared refresh counter and PWM timer.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_refresh <= '0;
            r_timer   <= '0;
        end else begin
            r_refresh <= w_tick ? '0 : r_refresh + 1'b1;
            r_timer   <= w_period_end ? '0 : r_timer + 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            localparam logic signed [ADC_W:0] W_DB_HI   = (ADC_W+1)'(DB_HI);
            localparam logic signed [ADC_W:0] W_DB_LO_N = -((ADC_W+1)'(DB_LO));

            logic signed [ADC_W:0] w_err;
            dir_t                  w_dir;
            logic [SUM_W-1:0]      w_sum;
            logic [CNT_W-1:0]      w_inc;
            logic [CNT_W-1:0]      w_dec;

            dir_t              r_dir;
            logic [CNT_W-1:0]  r_duty;
            logic [CNT_W-1:0]  r_shadow;
            logic              r_pwm;
            logic [LK_W-1:0]   r_lock;

            // One extra bit on each operand keeps the difference exact over
            // the full unsigned input range.
            assign w_err = $signed({1'b0, set_point[gi*ADC_W +: ADC_W]})
                         - $signed({1'b0, voltage[gi*ADC_W +: ADC_W]});

            always_comb begin
                w_dir = DIR_IDLE;
                if (w_err > W_DB_HI)
                    w_dir = DIR_INC;
                else if (w_err < W_DB_LO_N)
                    w_dir = DIR_DEC;
            end

            // Saturating step arithmetic, widened so neither direction wraps.
            assign w_sum = SUM_W'(r_duty) + SUM_W'(step);
            assign w_inc = (w_sum > SUM_W'(DUTY_MAX)) ? CNT_W'(DUTY_MAX) : w_sum[CNT_W-1:0];
            assign w_dec = (SUM_W'(r_duty) < SUM_W'(step)) ? '0 : r_duty - CNT_W'(step);

            always_ff @(posedge clock) begin
                if (!resetn) begin
                    r_dir    <= DIR_IDLE;
                    r_duty   <= '0;
                    r_shadow <= '0;
                    r_pwm    <= 1'b0;
                    r_lock   <= '0;
                end else begin
                    // Shadow reloads at the period boundary only, so a duty
                    // change mid-period cannot distort the running pulse.
                    if (w_period_end)
                        r_shadow <= r_duty;
                    r_pwm <= ch_en[gi] && (r_timer < r_shadow);

                    if (!ch_en[gi]) begin
                        // Duty is deliberately held so regulation resumes
                        // from where it left off on re-enable.
                        r_dir  <= DIR_IDLE;
                        r_lock <= '0;
                    end else if (w_tick) begin
                        r_dir <= w_dir;
                        case (w_dir)
                            DIR_INC: r_duty <= w_inc;
                            DIR_DEC: r_duty <= w_dec;
                            default: r_duty <= r_duty;
                        endcase
                        if (w_dir != DIR_IDLE)
                            r_lock <= '0;
                        else if (r_lock != LK_W'(LOCK_N))
                            r_lock <= r_lock + 1'b1;
                    end
                end
            end

            assign dir[gi*2 +: 2]         = r_dir;
            assign duty[gi*CNT_W +: CNT_W] = r_duty;
            assign pwm[gi]                = r_pwm;
            assign locked[gi]             = (r_lock == LK_W'(LOCK_N));
        end
    endgenerate

endmodule
